// File: rtl/opcode_type.sv
// Shared fetch-stage types and constants: FSM state encoding, bubble
// instruction encoding and PC arithmetic helpers.
package opcode_type;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } if_state_e;

  // addi x0, x0, 0 -- architectural no-op used as the pipeline bubble
  localparam logic [31:0] NOP_ENC    = 32'h0000_0013;
  localparam logic [31:0] PC_STEP    = 32'd4;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  // Force a byte address onto a word boundary; low two bits are dropped
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/if_stage_pc_reg.sv
// Program counter register: load has priority over sequential increment,
// enable gates the increment, otherwise the value is held.
module pc_reg
  import opcode_type::*;
#(
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic [31:0] q
);

  // PC update: redirect load wins, then +4 when enabled, else hold
  // NOTE: non-blocking assignment for every sequential register so all
  // flops sample pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= load_val;
    end else if (en) begin
      q <= q + PC_STEP;  // wraps naturally at 2^32
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, drives the external combinational
// instruction memory, and fills the IF/ID pipeline register. A taken
// branch/jump from EX redirects the PC and squashes the fetched slot.
module if_stage
  import opcode_type::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_ENC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        ex_is_taken,
  input  logic        ex_valid,
  input  logic [31:0] ex_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        flush_ex,
  output logic        misalign,
  output logic [31:0] redirect_cnt
);

  if_state_e   state;
  logic [31:0] pc;
  logic        redirect;
  logic        pc_advance;

  // A taken decision only counts when EX holds a real instruction
  assign redirect   = ex_is_taken & ex_valid;
  assign pc_advance = ~stall & (state == RUN);

  assign imem_addr = pc;
  assign flush_ex  = redirect;

  pc_reg #(
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk      (clk),
    .rst      (rst),
    .en       (pc_advance),
    .load     (redirect),
    .load_val (align_word(ex_target)),
    .q        (pc)
  );

  // Boot FSM: one bubble cycle after reset, then run forever
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
    end else begin
      state <= RUN;
    end
  end

  // IF/ID register: squash on redirect or boot, hold on stall, else capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_id_pc    <= RESET_PC;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (redirect || state == BOOT) begin
      if_id_pc    <= pc;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
    end else if (!stall) begin
      if_id_pc    <= pc;
      if_id_instr <= imem_rdata;
      if_id_valid <= 1'b1;
    end
  end

  // Status: misalignment pulse and redirect counter (stall-independent)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign     <= 1'b0;
      redirect_cnt <= 32'd0;
    end else begin
      misalign <= redirect & ex_target[1];
      if (redirect) begin
        redirect_cnt <= redirect_cnt + 32'd1;
      end
    end
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h0000_0013: bubble instruction (addi x0,x0,0).
REQ-003 SHALL have port clk  input  1: single clock, all state rising-edge.
REQ-004 SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-005 SHALL have port stall  input  1: hazard unit request to hold PC and IF/ID.
REQ-006 SHALL have port ex_is_taken  input  1: branch/jump decision from EX (branch_select output).
REQ-007 SHALL have port ex_valid  input  1: EX stage holds a real instruction.
REQ-008 SHALL have port ex_target  input  32: branch/jump target from EX ALU.
REQ-009 SHALL have port imem_addr  output  32: fetch address to combinational instruction memory.
REQ-010 SHALL have port imem_rdata  input  32: instruction word at imem_addr, same cycle.
REQ-011 SHALL have ports if_id_pc  output  32, if_id_instr  output  32, if_id_valid  output  1: IF/ID pipeline register.
REQ-012 SHALL have port flush_ex  output  1: combinational kill of instruction entering ID/EX.
REQ-013 SHALL have port misalign  output  1: registered one-cycle pulse, target bit 1 set.
REQ-014 SHALL have port redirect_cnt  output  32: count of accepted redirects.

Function
REQ-015 SHALL define redirect = ex_is_taken & ex_valid, combinational.
REQ-016 SHALL drive imem_addr = pc, combinational; flush_ex = redirect.
REQ-017 SHALL compute next pc by priority: redirect -> {ex_target[31:2],2'b00}; else stall or state BOOT -> pc; else pc+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0).
REQ-018 SHALL, on redirect, load if_id_instr=NOP_INSTR, if_id_valid=0, if_id_pc=pc, regardless of stall.
REQ-019 SHALL, on stall without redirect, hold all IF/ID fields.
REQ-020 SHALL otherwise capture if_id_pc=pc, if_id_instr=imem_rdata, if_id_valid=1.
REQ-021 SHALL implement FSM states BOOT, RUN: BOOT entered on reset; BOOT -> RUN unconditionally on first clock edge after reset release; RUN self-loops.
REQ-022 SHALL, in BOOT, hold pc and load IF/ID with NOP_INSTR, valid=0 (one-cycle bubble after reset).
REQ-023 SHALL pulse misalign the cycle after a redirect with ex_target[1]=1; ex_target[0] ignored silently.
REQ-024 SHALL increment redirect_cnt by 1 per redirect cycle, wrapping 32'hFFFF_FFFF -> 0; unaffected by stall.
REQ-025 SHALL treat ex_is_taken with ex_valid=0 as no event (no flush, no count).

Reset
REQ-026 SHALL, while rst=1 (asynchronously), force pc=RESET_PC, state=BOOT, if_id_pc=RESET_PC, if_id_instr=NOP_INSTR, if_id_valid=0, misalign=0, redirect_cnt=0.
REQ-027 SHALL abandon any in-progress redirect or stall when reset asserts mid-operation; no state survives reset.

Structure
REQ-028 SHALL place the if_state_e enum (BOOT, RUN) and the NOP encoding constant in the shared opcode_type package.
REQ-029 SHALL instantiate one sub-module, pc_reg (32-bit async-reset register with enable and load), for the PC.
REQ-030 SHALL contain no memory; instruction memory stays external.

Verification
REQ-031 Reset release, no stall -> cycle 1 if_id_valid=0; imem_addr sequence 0,0,4,8,C; if_id_pc 0 valid on cycle 2.
REQ-032 Redirect at pc=0x10, ex_target=0x100 -> next imem_addr=0x100, if_id_valid=0, if_id_instr=0x13, flush_ex=1 same cycle, redirect_cnt=1.
REQ-033 stall=1 and redirect same cycle, target 0x40 -> pc=0x40, IF/ID flushed; stall alone for 3 cycles -> pc and IF/ID unchanged.
REQ-034 ex_target=0x202 -> pc=0x200, misalign=1 for exactly one cycle; ex_target=0x201 -> pc=0x200, misalign=0.
REQ-035 Preload pc via redirect to 0xFFFF_FFFC -> next pc=0; force redirect_cnt to 0xFFFF_FFFF then redirect -> 0.
REQ-036 Assert rst mid-stall between clock edges -> outputs take reset values immediately, before next edge.
